mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Pipeline stage directly downstream of the execute stage. Performs data-memory loads/stores over a
//  req/ack bus, resolves taken branches and jumps back to fetch, and registers results for writeback.
//  Stalls the pipeline (stall=1) while a bus access is outstanding; bounded by a timeout counter.
// PARAMETERS
//  TIMEOUT     16   max cycles in S_REQ without dmem_ack before bus_error is raised (>=1)
//  TO_W        5    counter width, must hold TIMEOUT
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  we             in   1   writeback-register load enable from hazard unit
//  is_branch,alu_zero,is_jump   in 1 each   branch/jump control from execute
//  pc_branch,pc_jump            in 32 each  branch/jump targets from execute
//  mem_read,mem_write           in 1 each   access kind (mutually exclusive)
//  mem_type       in   1   0=word, 1=byte
//  mem_to_reg,reg_write         in 1 each   writeback control
//  alu_out        in   32  address (access) or result (non-access)
//  data_t         in   32  store data;  reg_addr in 5  destination register
//  dmem_req       out  1   bus request, held until dmem_ack
//  dmem_we        out  1   1=store;  dmem_addr out 32 word-aligned ({alu_out[31:2],2'b00})
//  dmem_wdata     out  32  store data; byte stores replicate data_t[7:0] to all lanes
//  dmem_be        out  4   byte enables: word=4'hF, byte=1<<alu_out[1:0]
//  dmem_ack       in   1   one-cycle ack; dmem_rdata in 32 valid with ack
//  stall          out  1   freeze upstream stages and PC
//  pc_src         out  1   redirect fetch (= is_branch&alu_zero | is_jump), combinational
//  pc_target      out  32  pc_jump if is_jump else pc_branch
//  reg_probe,data_probe,write_probe out 5/32/1  forwarding probe (reg_addr, alu_out, reg_write&~mem_to_reg)
//  wb_reg_write,wb_mem_to_reg out 1 each; wb_alu_out,wb_mem_data out 32 each; wb_reg_addr out 5
//  addr_error,bus_error   out 1 each  one-cycle fault flags registered alongside wb_*
// BEHAVIOUR
//  - Reset: state=S_IDLE, counter=0, every registered output 0; dmem_req=0, stall=0.
//  - access = mem_read|mem_write; misaligned = access & ~mem_type & (alu_out[1:0]!=0).
//  - FSM S_IDLE -> S_REQ on access&~misaligned (stall=1 in that cycle);
//    S_REQ: dmem_req=1, stall=1, counter++; on dmem_ack capture rdata -> S_DONE;
//    counter==TIMEOUT-1 without ack -> capture 0, set bus_err_pend -> S_DONE.
//    S_DONE: stall=0, wb_* load (if we), -> S_IDLE. Min access latency 2 stall cycles.
//  - Ack in same cycle as timeout: ack wins, no bus_error.
//  - dmem_req/we/addr/be/wdata stable throughout S_REQ; req never asserted in IDLE/DONE.
//  - Loads: word -> rdata; byte -> sign-extended lane alu_out[1:0] (lane 0 = rdata[7:0]).
//  - Non-access or misaligned: no bus cycle, no stall; wb_* load same cycle if we.
//    Misaligned: wb_reg_write=0, wb_mem_to_reg=0, addr_error=1 for that one cycle.
//  - bus_error: wb_reg_write forced 0 on faulted load; flag pulses with the DONE load.
//  - we=0: wb_* and fault flags hold; FSM still advances (bus is never abandoned).
//  - reset low mid-access: FSM to S_IDLE at once, dmem_req drops asynchronously, access lost.
//  - pc_src/pc_target purely combinational from inputs; unaffected by FSM.
// STRUCTURE
//  - Shared package/header: state encodings S_IDLE/S_REQ/S_DONE, byte-enable and lane constants.
//  - One sub-module: mem_align (combinational: store lane replicate + be, load lane select/sign-extend).
//  - FSM, timeout counter, wb registers in this module.
// TESTING
//  - Word load alu_out=0x100, ack after 3 cycles rdata=0xDEADBEEF -> stall 4 cycles, wb_mem_data=0xDEADBEEF.
//  - Byte store alu_out=0x203, data_t=0x12345678 -> dmem_be=4'b1000, wdata=0x78787878, addr=0x200.
//  - Byte load lane 2, rdata=0x00800000 -> wb_mem_data=0xFFFFFF80.
//  - Word load alu_out=0x102 -> no dmem_req, stall=0, addr_error=1, wb_reg_write=0.
//  - No ack, TIMEOUT=16 -> bus_error=1 after 16 REQ cycles, wb_reg_write=0, state S_IDLE.
//  - reset low during S_REQ -> dmem_req=0 immediately, all outputs 0; branch is_branch=1,alu_zero=1 -> pc_src=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encoding and byte-lane constants.
package mem_stage_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } mem_state_e;

   localparam logic [3:0] BE_WORD  = 4'hF;
   localparam logic [3:0] BE_LANE0 = 4'h1;
   localparam int         LANE_W   = 8;
endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store replication and byte enables, load lane select with sign extension.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic        mem_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data_t,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] load_data
);
   logic [LANE_W-1:0] lane_byte;

   always_comb begin
      case (addr_lo)
         2'd0:    lane_byte = rdata[7:0];
         2'd1:    lane_byte = rdata[15:8];
         2'd2:    lane_byte = rdata[23:16];
         default: lane_byte = rdata[31:24];
      endcase
      be        = mem_type ? (BE_LANE0 << addr_lo) : BE_WORD;
      wdata     = mem_type ? {4{data_t[7:0]}} : data_t;
      load_data = mem_type ? {{(32-LANE_W){lane_byte[LANE_W-1]}}, lane_byte} : rdata;
   end
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: data-memory bus access with timeout, branch/jump redirect, writeback registers.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic        is_branch,
   input  logic        alu_zero,
   input  logic        is_jump,
   input  logic [31:0] pc_branch,
   input  logic [31:0] pc_jump,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_type,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   input  logic [31:0] alu_out,
   input  logic [31:0] data_t,
   input  logic [4:0]  reg_addr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        pc_src,
   output logic [31:0] pc_target,
   output logic [4:0]  reg_probe,
   output logic [31:0] data_probe,
   output logic        write_probe,
   output logic        wb_reg_write,
   output logic        wb_mem_to_reg,
   output logic [31:0] wb_alu_out,
   output logic [31:0] wb_mem_data,
   output logic [4:0]  wb_reg_addr,
   output logic        addr_error,
   output logic        bus_error,
   output mem_state_e  dbg_state
);
   logic            access, misaligned, start, in_req;
   logic [31:0]     load_data, lane_wdata;
   logic [3:0]      lane_be;
   mem_state_e      state_q;
   logic [TO_W-1:0] cnt_q;
   logic            bus_err_pend_q;
   logic [31:0]     rdata_q;
   logic            wb_reg_write_q, wb_mem_to_reg_q, addr_error_q, bus_error_q;
   logic [31:0]     wb_alu_out_q, wb_mem_data_q;
   logic [4:0]      wb_reg_addr_q;

   mem_align u_align (
      .mem_type  (mem_type),
      .addr_lo   (alu_out[1:0]),
      .data_t    (data_t),
      .rdata     (dmem_rdata),
      .wdata     (lane_wdata),
      .be        (lane_be),
      .load_data (load_data)
   );

   always_comb begin
      access     = mem_read | mem_write;
      misaligned = access & ~mem_type & (alu_out[1:0] != 2'b00);
      start      = access & ~misaligned;
      in_req     = (state_q == S_REQ);
   end

   // Bus outputs come from held execute inputs, so they stay stable for the whole request.
   assign dmem_req   = in_req;
   assign dmem_we    = in_req & mem_write;
   assign dmem_addr  = in_req ? {alu_out[31:2], 2'b00} : 32'd0;
   assign dmem_wdata = in_req ? lane_wdata : 32'd0;
   assign dmem_be    = in_req ? lane_be : 4'd0;
   assign stall      = reset & (((state_q == S_IDLE) & start) | in_req);

   assign pc_src      = (is_branch & alu_zero) | is_jump;
   assign pc_target   = is_jump ? pc_jump : pc_branch;
   assign reg_probe   = reg_addr;
   assign data_probe  = alu_out;
   assign write_probe = reg_write & ~mem_to_reg;

   assign wb_reg_write  = wb_reg_write_q;
   assign wb_mem_to_reg = wb_mem_to_reg_q;
   assign wb_alu_out    = wb_alu_out_q;
   assign wb_mem_data   = wb_mem_data_q;
   assign wb_reg_addr   = wb_reg_addr_q;
   assign addr_error    = addr_error_q;
   assign bus_error     = bus_error_q;
   assign dbg_state     = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         bus_err_pend_q  <= 1'b0;
         rdata_q         <= '0;
         wb_reg_write_q  <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         wb_alu_out_q    <= '0;
         wb_mem_data_q   <= '0;
         wb_reg_addr_q   <= '0;
         addr_error_q    <= 1'b0;
         bus_error_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (start) begin
                  state_q <= S_REQ;
               end else if (we) begin
                  wb_reg_write_q  <= reg_write & ~misaligned;
                  wb_mem_to_reg_q <= mem_to_reg & ~misaligned;
                  wb_alu_out_q    <= alu_out;
                  wb_mem_data_q   <= '0;
                  wb_reg_addr_q   <= reg_addr;
                  addr_error_q    <= misaligned;
                  bus_error_q     <= 1'b0;
               end
            end
            S_REQ: begin
               // An ack on the last allowed cycle still completes the access normally.
               if (dmem_ack) begin
                  rdata_q        <= mem_read ? load_data : 32'd0;
                  bus_err_pend_q <= 1'b0;
                  state_q        <= S_DONE;
               end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                  rdata_q        <= '0;
                  bus_err_pend_q <= 1'b1;
                  state_q        <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + TO_W'(1);
               end
            end
            S_DONE: begin
               state_q        <= S_IDLE;
               cnt_q          <= '0;
               bus_err_pend_q <= 1'b0;
               if (we) begin
                  wb_reg_write_q  <= reg_write & ~bus_err_pend_q;
                  wb_mem_to_reg_q <= mem_to_reg;
                  wb_alu_out_q    <= alu_out;
                  wb_mem_data_q   <= rdata_q;
                  wb_reg_addr_q   <= reg_addr;
                  addr_error_q    <= 1'b0;
                  bus_error_q     <= bus_err_pend_q;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
